// File: rtl/br_ram_init_scheduler_pkg.sv
// rtl/br_ram_init_scheduler_pkg.sv - shared types for the RAM init scheduler
// Purpose: scheduler state encoding and a helper for sizing the drain counter.
package br_ram_init_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    INIT  = 2'd2,
    READY = 2'd3
  } sched_state_t;

  // Bits needed to hold a down-counter loaded with n; never below 1 so a
  // zero-latency RAM still gets a legal (unused) counter.
  function automatic int count_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/br_ram_initializer.sv
// rtl/br_ram_initializer.sv - sequential fill sweep over every RAM entry
// Purpose: on a start pulse, capture fill_value and issue one write per cycle
//   to addresses 0..Depth-1, then go quiet.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   start             launch a sweep (ignored while a sweep is running)
//   fill_value        value captured at launch and written to every entry
//   busy              high on every cycle that carries a sweep write
//   last              high on the cycle writing entry Depth-1
//   wr_addr, wr_data  current sweep write address / data
module br_ram_initializer #(
  parameter int Depth = 2,
  parameter int Width = 1,
  localparam int AddressWidth = $clog2(Depth)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [Width-1:0]        fill_value,
  output logic                    busy,
  output logic                    last,
  output logic [AddressWidth-1:0] wr_addr,
  output logic [Width-1:0]        wr_data
);

  // The address stops at Depth-1 and never wraps; busy drops on that write.
  assign last = busy && (wr_addr == AddressWidth'(Depth - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy    <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (start && !busy) begin
      busy    <= 1'b1;
      wr_addr <= '0;
      wr_data <= fill_value;
    end else if (busy) begin
      if (last) begin
        busy <= 1'b0;
      end else begin
        wr_addr <= wr_addr + AddressWidth'(1);
      end
    end
  end

endmodule

// File: rtl/br_ram_init_scheduler.sv
// rtl/br_ram_init_scheduler.sv - gates user traffic and sequences RAM initialization
// Purpose: owns a RAM's write and read-address ports; after reset or reinit_req
//   it drains in-flight reads, sweeps every entry to initial_value and then
//   passes user traffic straight through with zero latency.
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   initial_value, reinit_req    fill value, single-cycle re-init request
//   busy, init_done              DRAIN/INIT indication, READY indication
//   usr_wr_*                     user write handshake, address, data
//   usr_rd_addr_*                user read-address handshake, address
//   ram_wr_*, ram_rd_addr_*      RAM write strobe/address/data, read strobe/address
module br_ram_init_scheduler
  import br_ram_init_scheduler_pkg::*;
#(
  parameter int Depth = 2,
  parameter int Width = 1,
  parameter int RamReadLatency = 1,
  parameter bit AutoInitOnReset = 1'b1,
  localparam int AddressWidth = $clog2(Depth)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [Width-1:0]        initial_value,
  input  logic                    reinit_req,
  output logic                    busy,
  output logic                    init_done,
  input  logic                    usr_wr_valid,
  output logic                    usr_wr_ready,
  input  logic [AddressWidth-1:0] usr_wr_addr,
  input  logic [Width-1:0]        usr_wr_data,
  input  logic                    usr_rd_addr_valid,
  output logic                    usr_rd_addr_ready,
  input  logic [AddressWidth-1:0] usr_rd_addr,
  output logic                    ram_wr_valid,
  output logic [AddressWidth-1:0] ram_wr_addr,
  output logic [Width-1:0]        ram_wr_data,
  output logic                    ram_rd_addr_valid,
  output logic [AddressWidth-1:0] ram_rd_addr
);

  localparam int CntWidth = count_width(RamReadLatency);

  sched_state_t          state, state_next;
  logic                  fresh;      // first cycle out of reset
  logic [CntWidth-1:0]   drain_cnt;
  logic                  sweep_start;
  logic                  sweep_busy;
  logic                  sweep_last;
  logic [AddressWidth-1:0] sweep_addr;
  logic [Width-1:0]      sweep_data;

  br_ram_initializer #(
    .Depth (Depth),
    .Width (Width)
  ) u_initializer (
    .clk        (clk),
    .rst        (rst),
    .start      (sweep_start),
    .fill_value (initial_value),
    .busy       (sweep_busy),
    .last       (sweep_last),
    .wr_addr    (sweep_addr),
    .wr_data    (sweep_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      fresh     <= 1'b1;
      drain_cnt <= '0;
    end else begin
      state <= state_next;
      fresh <= 1'b0;
      if (state_next == DRAIN && state != DRAIN) begin
        drain_cnt <= CntWidth'(RamReadLatency);
      end else if (state == DRAIN) begin
        drain_cnt <= drain_cnt - CntWidth'(1);
      end
    end
  end

  // The initializer is launched on the same edge that enters INIT, so its busy
  // and the INIT state cover exactly the same Depth cycles.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (fresh && AutoInitOnReset) begin
          state_next = INIT;   // nothing can be in flight straight out of reset
        end else if (reinit_req) begin
          state_next = (RamReadLatency == 0) ? INIT : DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt == CntWidth'(1)) state_next = INIT;
      end
      INIT: begin
        if (sweep_last) state_next = READY;
      end
      READY: begin
        if (reinit_req) state_next = (RamReadLatency == 0) ? INIT : DRAIN;
      end
      default: state_next = IDLE;
    endcase
    sweep_start = (state_next == INIT) && (state != INIT);
  end

  // Outputs are forced low whenever reset is held, including the cycle it is
  // first asserted.
  always_comb begin
    busy              = 1'b0;
    init_done         = 1'b0;
    usr_wr_ready      = 1'b0;
    usr_rd_addr_ready = 1'b0;
    ram_wr_valid      = 1'b0;
    ram_wr_addr       = '0;
    ram_wr_data       = '0;
    ram_rd_addr_valid = 1'b0;
    ram_rd_addr       = '0;
    if (rst) begin
      case (state)
        DRAIN: busy = 1'b1;
        INIT: begin
          busy         = 1'b1;
          ram_wr_valid = sweep_busy;
          ram_wr_addr  = sweep_busy ? sweep_addr : '0;
          ram_wr_data  = sweep_busy ? sweep_data : '0;
        end
        READY: begin
          init_done         = 1'b1;
          usr_wr_ready      = 1'b1;
          usr_rd_addr_ready = 1'b1;
          ram_wr_valid      = usr_wr_valid;
          ram_wr_addr       = usr_wr_addr;
          ram_wr_data       = usr_wr_data;
          ram_rd_addr_valid = usr_rd_addr_valid;
          ram_rd_addr       = usr_rd_addr;
        end
        default: ;
      endcase
    end
  end

  // Non-power-of-two depths leave unused address codes on the user ports.
  a_wr_addr_range: assert property (@(posedge clk) disable iff (!rst)
    (state == READY && usr_wr_valid) |-> (int'(usr_wr_addr) < Depth));
  a_rd_addr_range: assert property (@(posedge clk) disable iff (!rst)
    (state == READY && usr_rd_addr_valid) |-> (int'(usr_rd_addr) < Depth));

endmodule
